// File: rtl/pll_hdmi_cfg_pkg.sv
// pll_hdmi_cfg_pkg: sequencer states, reconfig register map and staging-entry helper.
package pll_hdmi_cfg_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_MODE, S_WRITE, S_READ, S_START, S_GUARD, S_WAIT, S_DONE, S_ERR
    } state_e;
    typedef enum logic [5:0] {
        A_MODE = 6'h00, A_STATUS = 6'h01, A_START = 6'h02, A_N = 6'h03, A_M = 6'h04,
        A_C = 6'h05, A_DPS = 6'h06, A_K = 6'h07, A_BW = 6'h08, A_CP = 6'h09
    } reg_addr_e;
    localparam int GUARD_LEN = 4;
    function automatic logic [37:0] entry(input logic [5:0] a, input logic [31:0] d);
        return {a, d};
    endfunction
endpackage

// File: rtl/pll_hdmi_cfg_if.sv
// pll_hdmi_cfg_if: Avalon-MM management port of the PLL reconfiguration IP.
interface pll_hdmi_cfg_if;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    modport master (
        output mgmt_address, mgmt_writedata, mgmt_write, mgmt_read,
        input  mgmt_readdata, mgmt_waitrequest
    );
    modport slave (
        input  mgmt_address, mgmt_writedata, mgmt_write, mgmt_read,
        output mgmt_readdata, mgmt_waitrequest
    );
endinterface

// File: rtl/pll_hdmi_cfg_fifo.sv
// pll_hdmi_cfg_fifo: staging FIFO exposing the head and the entry behind it for back-to-back issue.
module pll_hdmi_cfg_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic [W-1:0] next_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         last_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0] wp_q, rp_q, cnt;
    logic [AW-1:0] rn;
    assign cnt     = wp_q - rp_q;
    assign full_o  = cnt == (AW+1)'(DEPTH);
    assign empty_o = cnt == '0;
    assign last_o  = cnt == (AW+1)'(1);
    assign rn      = rp_q[AW-1:0] + 1'b1;
    assign head_o  = mem_q[rp_q[AW-1:0]];
    assign next_o  = mem_q[rn];
    always_ff @(posedge clk)
        if (push_i && !full_o) mem_q[wp_q[AW-1:0]] <= data_i;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else if (flush_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push_i && !full_o) wp_q <= wp_q + 1'b1;
            if (pop_i && !empty_o) rp_q <= rp_q + 1'b1;
        end
endmodule

// File: rtl/pll_hdmi_cfg.sv
// pll_hdmi_cfg: replays staged PLL reconfig writes over Avalon-MM (MODE, entries, START), then waits for relock.
// Define PLL_HDMI_CFG_READBACK_EN to verify each entry with a read of the same address.
module pll_hdmi_cfg
    import pll_hdmi_cfg_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [5:0]     wr_addr,
    input  logic [31:0]    wr_data,
    input  logic           commit,
    output logic           busy,
    output logic           done,
    output logic           error,
    input  logic           pll_locked,
    pll_hdmi_cfg_if.master mgmt
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    state_e state_q;
    logic busy_q, done_q, error_q, up_q, wr_q, rd_q;
    logic [5:0] addr_q;
    logic [31:0] data_q;
    logic [TW-1:0] cnt_q;
    logic [1:0] sync_q;
    logic push, pop, flush, full, empty, last, go, ack, lock_s;
    logic [37:0] head, nxt;
    assign lock_s   = sync_q[1];
    assign ack      = !mgmt.mgmt_waitrequest;
    assign wr_ready = up_q && !full && !busy_q;
    assign push     = wr_valid && wr_ready;
    assign go       = commit && !busy_q;
    assign pop      = state_q == S_WRITE && ack;
`ifdef PLL_HDMI_CFG_READBACK_EN
    assign flush = state_q == S_READ && ack && mgmt.mgmt_readdata != data_q;
`else
    logic unused_rd;
    assign unused_rd = ^mgmt.mgmt_readdata;
    assign flush     = 1'b0;
`endif
    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;
    assign mgmt.mgmt_address   = addr_q;
    assign mgmt.mgmt_writedata = data_q;
    assign mgmt.mgmt_write     = wr_q;
    assign mgmt.mgmt_read      = rd_q;
    pll_hdmi_cfg_fifo #(.DEPTH(DEPTH), .W(38)) u_fifo (
        .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .flush_i(flush),
        .data_i(entry(wr_addr, wr_data)), .head_o(head), .next_o(nxt),
        .full_o(full), .empty_o(empty), .last_o(last)
    );
    // Bus registers only move on completion (ack), which keeps a stalled request stable.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            up_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            sync_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
            up_q   <= 1'b1;
            case (state_q)
                S_MODE: if (ack) begin
                    addr_q  <= head[37:32];
                    data_q  <= head[31:0];
                    state_q <= S_WRITE;
                end
                S_WRITE: if (ack) begin
`ifdef PLL_HDMI_CFG_READBACK_EN
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b1;
                    state_q <= S_READ;
`else
                    if (last) begin
                        addr_q  <= A_START;
                        data_q  <= '0;
                        state_q <= S_START;
                    end else begin
                        addr_q <= nxt[37:32];
                        data_q <= nxt[31:0];
                    end
`endif
                end
                S_READ: if (ack) begin
                    rd_q <= 1'b0;
                    if (flush) begin
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        wr_q    <= 1'b1;
                        addr_q  <= empty ? A_START : head[37:32];
                        data_q  <= empty ? '0 : head[31:0];
                        state_q <= empty ? S_START : S_WRITE;
                    end
                end
                S_START: if (ack) begin
                    wr_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_GUARD;
                end
                S_GUARD: begin
                    cnt_q   <= cnt_q == TW'(GUARD_LEN - 1) ? '0 : cnt_q + 1'b1;
                    state_q <= cnt_q == TW'(GUARD_LEN - 1) ? S_WAIT : S_GUARD;
                end
                S_WAIT: if (lock_s) begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    busy_q  <= 1'b0;
                    error_q <= 1'b1;
                    state_q <= S_ERR;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (go) begin
                        error_q <= 1'b0;
                        if (empty && !push) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            wr_q    <= 1'b1;
                            addr_q  <= A_MODE;
                            data_q  <= '0;
                            state_q <= S_MODE;
                        end
                    end
                end
            endcase
        end
endmodule

// File: tb/tb_pll_hdmi_cfg.sv
// tb_pll_hdmi_cfg: directed + randomized checks of the reconfig sequencer against a transfer-list model.
module tb_pll_hdmi_cfg;
    import pll_hdmi_cfg_pkg::*;
    typedef struct {logic [5:0] a; logic [31:0] d; int c;} rec_t;
    logic clk, rst, wr_valid, wr_ready, commit, busy, done, error, pll_locked;
    logic [5:0] wr_addr;
    logic [31:0] wr_data;
    pll_hdmi_cfg_if mif();
    pll_hdmi_cfg #(.DEPTH(16), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .busy(busy), .done(done), .error(error),
        .pll_locked(pll_locked), .mgmt(mif)
    );
    int n_chk = 0, n_pass = 0, cyc = 0;
    int stall_pct = 0, start_hold = 0, bad_addr = -1, hold_left = 0;
    bit pend = 0;
    logic [39:0] sv_bus;
    logic [31:0] mem [64];
    rec_t mon_q[$];
    logic [37:0] ents[$];
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    // Avalon slave: random stalls, long START hold, memory-backed reads, completed-write log.
    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
            hold_left = 0;
            mif.mgmt_waitrequest = 0;
            mif.mgmt_readdata = 0;
        end else begin
            if (pend)
                chk("hold_bus", {mif.mgmt_write, mif.mgmt_read, mif.mgmt_address, mif.mgmt_writedata}, sv_bus);
            if (mif.mgmt_write || mif.mgmt_read) begin
                chk("one_strobe", mif.mgmt_write && mif.mgmt_read, 0);
                if (!pend)
                    hold_left = (mif.mgmt_write && mif.mgmt_address == 6'h02) ? start_hold :
                                ($urandom_range(99) < stall_pct ? $urandom_range(3, 1) : 0);
            end
            mif.mgmt_waitrequest = (mif.mgmt_write || mif.mgmt_read) && hold_left > 0;
            if (hold_left > 0) hold_left--;
            if (mif.mgmt_read)
                mif.mgmt_readdata = mem[mif.mgmt_address] ^ ((int'(mif.mgmt_address) == bad_addr) ? 32'h1 : 32'h0);
            if (mif.mgmt_write && !mif.mgmt_waitrequest) begin
                mem[mif.mgmt_address] = mif.mgmt_writedata;
                mon_q.push_back('{mif.mgmt_address, mif.mgmt_writedata, cyc});
            end
            pend = (mif.mgmt_write || mif.mgmt_read) && mif.mgmt_waitrequest;
            sv_bus = {mif.mgmt_write, mif.mgmt_read, mif.mgmt_address, mif.mgmt_writedata};
        end
    end
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    task automatic load(input logic [37:0] e);
        wr_valid = 1;
        wr_addr = e[37:32];
        wr_data = e[31:0];
        chk("load_ready", wr_ready, 1);
        step();
        wr_valid = 0;
    endtask
    task automatic empty_commit(input string tag);
        mon_q.delete();
        commit = 1;
        step();
        commit = 0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, error, 0);
        chk({tag, "_busy"}, busy, 0);
        step();
        step();
        chk({tag, "_nowr"}, mon_q.size(), 0);
        chk({tag, "_pulse"}, done, 0);
    endtask
    task automatic rand_ents(input int n);
        ents.delete();
        for (int i = 0; i < n; i++) ents.push_back(entry(6'($urandom_range(9, 3)), $urandom()));
    endtask
    // Model: bus shows MODE, the entries in order, START; relock/timeout timing follows from START completion.
    task automatic run(input int stall, input int hold, input int lock_dly, input bit merge, input bit poke, input bit pre);
        int n, c0, s, ev_c, exp_c;
        bit ev_d;
        logic [37:0] exp_q[$];
        n = ents.size();
        s = -1;
        ev_c = -1;
        ev_d = 0;
        stall_pct = stall;
        start_hold = hold;
        exp_q.push_back(entry(6'h00, 0));
        foreach (ents[i]) exp_q.push_back(ents[i]);
        exp_q.push_back(entry(6'h02, 0));
        if (!pre)
            for (int i = 0; i < n - int'(merge); i++) load(ents[i]);
        mon_q.delete();
        commit = 1;
        if (merge) begin
            wr_valid = 1;
            wr_addr = ents[n-1][37:32];
            wr_data = ents[n-1][31:0];
            chk("merge_ready", wr_ready, 1);
        end
        c0 = cyc;
        step();
        commit = 0;
        wr_valid = 0;
        chk("busy_after_commit", busy, 1);
        for (int k = 0; k < 3000; k++) begin
            commit = 0;
            wr_valid = 0;
            if (poke && cyc == c0 + 2) begin
                commit = 1;
                wr_valid = 1;
                chk("wr_ready_busy", wr_ready, 0);
            end
            if (s < 0)
                foreach (mon_q[i]) if (mon_q[i].a == 6'h02 && s < 0) s = mon_q[i].c;
            if (lock_dly >= 0 && s >= 0 && cyc == s + lock_dly) pll_locked = 1;
            if (done || error) begin
                ev_c = cyc;
                ev_d = done;
                break;
            end
            step();
        end
        commit = 0;
        wr_valid = 0;
        chk("seq_end", ev_c >= 0, 1);
        chk("wr_count", mon_q.size(), exp_q.size());
        foreach (mon_q[i])
            if (i < exp_q.size()) chk($sformatf("wr%0d", i), {mon_q[i].a, mon_q[i].d}, exp_q[i]);
`ifdef PLL_HDMI_CFG_READBACK_EN
        if (stall == 0 && hold == 0) chk("start_cycle", s, c0 + 2 * n + 2);
`else
        if (stall == 0 && hold == 0) chk("start_cycle", s, c0 + n + 2);
`endif
        if (lock_dly >= 0) begin
            exp_c = (s + lock_dly + 3 > s + 6) ? s + lock_dly + 3 : s + 6;
            chk("done_seen", ev_d, 1);
            chk("done_cycle", ev_c, exp_c);
            chk("done_error", error, 0);
        end else begin
            chk("timeout_error", error, 1);
            chk("timeout_cycle", ev_c, s + 5 + 100);
            chk("timeout_done", done, 0);
        end
        chk("busy_end", busy, 0);
        step();
        chk("done_once", done, 0);
        pll_locked = 0;
        repeat (3) step();
    endtask
    initial begin
        int c0;
        wr_valid = 0;
        wr_addr = 0;
        wr_data = 0;
        commit = 0;
        pll_locked = 0;
        rst = 1;
        step();
        step();
        chk("rst_outs", {wr_ready, busy, done, error, mif.mgmt_write, mif.mgmt_read}, 0);
        chk("rst_bus", {mif.mgmt_address, mif.mgmt_writedata}, 0);
        rst = 0;
        step();
        chk("rel_ready", wr_ready, 1);
        ents = {entry(A_M, 32'h0000_0808), entry(A_N, 32'h0001_0000), entry(A_C, 32'h0000_0404)};
        run(0, 0, 10, 0, 0, 0);
        rand_ents(2);
        run(0, 50, 10, 0, 1, 0);
        empty_commit("poke_empty");
        for (int r = 0; r < 3; r++) begin
            rand_ents($urandom_range(8, 1));
            run(30, 0, $urandom_range(20), r == 1, 0, 0);
        end
        rand_ents(2);
        run(0, 0, -1, 0, 0, 0);
        empty_commit("after_timeout");
        rand_ents(16);
        foreach (ents[i]) load(ents[i]);
        wr_valid = 1;
        wr_data = 32'hDEAD_BEEF;
        chk("full_ready", wr_ready, 0);
        step();
        wr_valid = 0;
        run(20, 0, 4, 0, 0, 1);
        empty_commit("after_full");
        rand_ents(4);
        stall_pct = 0;
        start_hold = 0;
        foreach (ents[i]) load(ents[i]);
        commit = 1;
        c0 = cyc;
        step();
        commit = 0;
        while (cyc < c0 + 3) step();
        chk("mid_bus", {mif.mgmt_write, mif.mgmt_address}, {1'b1, ents[1][37:32]});
        rst = 1;
        #1;
        chk("mid_rst_outs", {wr_ready, busy, done, error, mif.mgmt_write, mif.mgmt_read}, 0);
        chk("mid_rst_bus", {mif.mgmt_address, mif.mgmt_writedata}, 0);
        @(negedge clk);
        #1;
        rst = 0;
        step();
        chk("mid_rel_ready", wr_ready, 1);
        empty_commit("after_rst");
`ifdef PLL_HDMI_CFG_READBACK_EN
        ents = {entry(A_M, 32'h0000_0808), entry(A_N, 32'h0001_0000), entry(A_C, 32'h0000_0404)};
        foreach (ents[i]) load(ents[i]);
        bad_addr = 4;
        mon_q.delete();
        commit = 1;
        step();
        commit = 0;
        for (int k = 0; k < 200 && !error; k++) step();
        chk("rb_error", error, 1);
        chk("rb_busy", busy, 0);
        chk("rb_writes", mon_q.size(), 2);
        foreach (mon_q[i]) chk("rb_no_start", mon_q[i].a == 6'h02, 0);
        bad_addr = -1;
        empty_commit("rb_flushed");
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pll_hdmi_cfg.md
# pll_hdmi_cfg

Avalon-MM reconfiguration sequencer for the HDMI pixel PLL. The video-mode logic loads a short list of PLL reconfiguration register writes, such as M, N, C counters, bandwidth and charge pump, into a staging FIFO and issues `commit`. The block then drives the PLL reconfiguration IP's management port through MODE, the staged writes, and START. It waits for relock and reports `done` or `error`. It sits between the video-mode logic and the reconfiguration IP attached to the PLL's reconfig buses.

## Interface
Parameters:
- `DEPTH`, 16: staging FIFO entries; power of two, 2..64.
- `TIMEOUT`, 2_000_000: cycles allowed for relock after START completes.

Ports:
- `clk`  in  1  management clock; all logic is in this domain.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  staging write strobe.
- `wr_ready`  out  1  equals `!full && !busy`; a transfer occurs when `wr_valid && wr_ready`.
- `wr_addr`  in  6  reconfiguration register address.
- `wr_data`  in  32  reconfiguration register data.
- `commit`  in  1  single-cycle start request.
- `busy`  out  1  high from the cycle after an accepted commit until `done` or `error`.
- `done`  out  1  one-cycle success pulse.
- `error`  out  1  sticky failure flag; cleared by the next accepted commit.
- `pll_locked`  in  1  asynchronous PLL lock indication.
- `mgmt_address`  out  6  Avalon-MM master address.
- `mgmt_writedata`  out  32  Avalon-MM master write data.
- `mgmt_write`  out  1  Avalon-MM write request.
- `mgmt_read`  out  1  Avalon-MM read request.
- `mgmt_readdata`  in  32  Avalon-MM read data.
- `mgmt_waitrequest`  in  1  Avalon-MM stall.

## Operation
- Reset values: all `mgmt_*` outputs 0, `busy`/`done`/`error` 0, FIFO empty, state IDLE. `wr_ready` becomes 1 once reset is released.
- `pll_locked` passes through a 2-flop synchronizer to produce `lock_s`.
- States and transitions:
  - IDLE → MODE on `commit` with FIFO non-empty.
  - MODE → WRITE.
  - WRITE → START when the FIFO is empty.
  - START → GUARD.
  - GUARD → WAIT_LOCK.
  - WAIT_LOCK → DONE or ERR.
  - DONE and ERR → IDLE.
- MODE: write address 0x00, data 0 (waitrequest mode).
- WRITE: one write per FIFO entry, in order. An entry is popped on the cycle its write completes.
- START: write address 0x02, data 0. The reconfiguration IP holds `mgmt_waitrequest` high until the PLL is reprogrammed.
- GUARD: ignore `lock_s` for 4 cycles.
- WAIT_LOCK: leave on `lock_s` = 1, or on TIMEOUT cycles elapsed → ERR.
- DONE pulses `done`. ERR sets `error` and flushes the FIFO.
- Avalon rules:
  - A request holds address, data and strobe stable until the cycle in which `mgmt_waitrequest` = 0; that cycle completes the transfer.
  - At most one of `mgmt_write`/`mgmt_read` is high.
  - Strobes drop the cycle after completion unless the next transfer issues back-to-back.
- Boundaries:
  - `commit` with empty FIFO: no bus activity; `done` pulses the next cycle and `error` clears.
  - `commit` while `busy` is ignored.
  - `wr_valid` while `busy` is not accepted.
  - A full FIFO drops `wr_ready`.
  - Simultaneous `commit` and an accepted write: the entry is included in the sequence.
  - Reset mid-sequence aborts at once and clears the FIFO. The PLL is left as-is; the caller re-commits.

## Timing
- With no stalls and N entries, `commit` is sampled in cycle 0:
  - MODE write in cycle 1.
  - Entries in cycles 2..N+1.
  - START in cycle N+2.
  - GUARD occupies cycles N+3..N+6.
  - `done` pulses the cycle after `lock_s` is first seen high in WAIT_LOCK.
- Each stall cycle adds one cycle.
- The timeout counter is 22 bits wide (sized from TIMEOUT via $clog2). It is cleared on entering WAIT_LOCK.

## Configuration
- `PLL_HDMI_CFG_READBACK_EN` defined:
  - After each entry write, a read of the same address is issued.
  - A mismatch between `mgmt_readdata` and the written data → ERR. No START is issued and the FIFO is flushed.
  - Each entry takes at least 2 cycles.
- Not defined: `mgmt_read` is tied 0 and `mgmt_readdata` is ignored.

## Structure
- Package `pll_hdmi_cfg_pkg`:
  - State enum.
  - Register address constants: MODE 0x00, STATUS 0x01, START 0x02, N 0x03, M 0x04, C 0x05, DPS 0x06, K 0x07, BW 0x08, CP 0x09.
  - Guard length constant (4).
- Sub-module `pll_hdmi_cfg_fifo`: synchronous 38-bit FIFO with push/pop, `full` and `empty` flags, and a `flush` input.

## Test plan
- Load 3 entries (M=0x0000_0808, N=0x0001_0000, C=0x0000_0404), commit, no stalls:
  - Writes appear in order 0x00, 0x04, 0x03, 0x05, 0x02, START in cycle 5.
  - Raise `pll_locked` 10 cycles later → one `done` pulse.
- START held in waitrequest for 50 cycles:
  - `mgmt_write`, address 0x02 and data stay stable throughout.
  - No GUARD entry before completion.
- `pll_locked` held low with TIMEOUT=100 → `error` = 1 exactly 100 cycles after WAIT_LOCK entry, `busy` = 0, FIFO empty.
- Fill all 16 entries, then drive a 17th `wr_valid`: `wr_ready` = 0 and the 17th entry is not stored. Commit with an empty FIFO → `done` next cycle, no `mgmt_write`.
- Assert `rst` during the 2nd entry write → all outputs 0 in the same cycle. After release, `wr_ready` = 1 and the FIFO is empty.
- With `PLL_HDMI_CFG_READBACK_EN`, return readdata ≠ written data for the M entry → ERR, no address-0x02 write, `error` = 1.
